// File: rtl/audio_elapsed_timer.sv
// Elapsed-time counter for the recorder: whole seconds in binary and BCD,
// driven by debounced record/play, pause and stop key pulses.
module audio_elapsed_timer #(
  parameter int unsigned CLK_FREQ = 12000000,
  parameter int unsigned MAX_SEC  = 32
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_pause,
  input  logic       i_stop,
  output logic [6:0] o_seconds,
  output logic [3:0] o_sec_tens,
  output logic [3:0] o_sec_ones,
  output logic       o_running,
  output logic       o_limit
);

  localparam int unsigned PW = $clog2(CLK_FREQ);
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_FREQ - 1);
  localparam logic [6:0]    SEC_LAST = 7'(MAX_SEC - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t        state;
  logic [PW-1:0] prescaler;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      prescaler  <= '0;
      o_seconds  <= '0;
      o_sec_tens <= '0;
      o_sec_ones <= '0;
      o_running  <= 1'b0;
      o_limit    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!i_stop && i_start) begin
            prescaler  <= '0;
            o_seconds  <= '0;
            o_sec_tens <= '0;
            o_sec_ones <= '0;
            o_limit    <= 1'b0;
            o_running  <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          // A start in RUN is ignored, so it also masks a same-cycle pause.
          if (i_stop) begin
            state     <= IDLE;
            o_running <= 1'b0;
          end else if (i_pause && !i_start) begin
            state     <= PAUSE;
            o_running <= 1'b0;
          end else if (prescaler == PRE_LAST) begin
            prescaler <= '0;
            o_seconds <= o_seconds + 7'd1;
            if (o_sec_ones == 4'd9) begin
              o_sec_ones <= '0;
              o_sec_tens <= o_sec_tens + 4'd1;
            end else begin
              o_sec_ones <= o_sec_ones + 4'd1;
            end
            if (o_seconds == SEC_LAST) begin
              o_limit   <= 1'b1;
              o_running <= 1'b0;
              state     <= IDLE;
            end
          end else begin
            prescaler <= prescaler + PW'(1);
          end
        end
        PAUSE: begin
          if (i_stop) begin
            state <= IDLE;
          end else if (i_start || i_pause) begin
            state     <= RUN;
            o_running <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          o_running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_audio_elapsed_timer.sv
// Bench for audio_elapsed_timer: three configurations checked against an
// elapsed-run-cycle reference model plus directed boundary checks.
module tb_audio_elapsed_timer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst   = '1;
  logic [2:0] start = '0;
  logic [2:0] pause = '0;
  logic [2:0] stop  = '0;
  logic [6:0] sec  [3];
  logic [3:0] tens [3];
  logic [3:0] ones [3];
  logic [2:0] run;
  logic [2:0] lim;

  int vectors = 0;
  int errs    = 0;

  audio_elapsed_timer #(.CLK_FREQ(10), .MAX_SEC(32)) u0 (
    .i_clk(clk), .i_rst(rst[0]), .i_start(start[0]), .i_pause(pause[0]), .i_stop(stop[0]),
    .o_seconds(sec[0]), .o_sec_tens(tens[0]), .o_sec_ones(ones[0]),
    .o_running(run[0]), .o_limit(lim[0]));
  audio_elapsed_timer #(.CLK_FREQ(4), .MAX_SEC(12)) u1 (
    .i_clk(clk), .i_rst(rst[1]), .i_start(start[1]), .i_pause(pause[1]), .i_stop(stop[1]),
    .o_seconds(sec[1]), .o_sec_tens(tens[1]), .o_sec_ones(ones[1]),
    .o_running(run[1]), .o_limit(lim[1]));
  audio_elapsed_timer #(.CLK_FREQ(2), .MAX_SEC(99)) u2 (
    .i_clk(clk), .i_rst(rst[2]), .i_start(start[2]), .i_pause(pause[2]), .i_stop(stop[2]),
    .o_seconds(sec[2]), .o_sec_tens(tens[2]), .o_sec_ones(ones[2]),
    .o_running(run[2]), .o_limit(lim[2]));

  // Reference model: seconds are simply counted RUN cycles divided by CLK_FREQ.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;
  int freq [3] = '{10, 4, 2};
  int maxs [3] = '{32, 12, 99};
  int mode [3] = '{M_IDLE, M_IDLE, M_IDLE};
  int elapsed [3] = '{0, 0, 0};
  bit mlim [3] = '{1'b0, 1'b0, 1'b0};

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst[i]) begin
        mode[i] = M_IDLE; elapsed[i] = 0; mlim[i] = 1'b0;
      end else if (mode[i] == M_IDLE) begin
        if (!stop[i] && start[i]) begin
          elapsed[i] = 0; mlim[i] = 1'b0; mode[i] = M_RUN;
        end
      end else if (mode[i] == M_RUN) begin
        if (stop[i]) mode[i] = M_IDLE;
        else if (pause[i] && !start[i]) mode[i] = M_PAUSE;
        else begin
          elapsed[i]++;
          if (elapsed[i] == maxs[i] * freq[i]) begin
            mlim[i] = 1'b1; mode[i] = M_IDLE;
          end
        end
      end else begin
        if (stop[i]) mode[i] = M_IDLE;
        else if (start[i] || pause[i]) mode[i] = M_RUN;
      end
    end
  end

  function automatic logic [16:0] exp_v(int i);
    int s;
    s = elapsed[i] / freq[i];
    return {mode[i] == M_RUN, mlim[i], 7'(s), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [16:0] obs_v(int i);
    return {run[i], lim[i], sec[i], tens[i], ones[i]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    start = '0; pause = '0; stop = '0;
  endtask

  task automatic test_reset();
    rst = '1;
    tick(); tick();
    rst = '0;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (obs_v(i) !== 17'd0) begin
        errs++; $display("FAIL reset dut%0d: got %h want 0", i, obs_v(i));
      end
    end
    pause[0] = 1'b1; tick();
    stop[0] = 1'b1; tick();
    vectors++;
    if (obs_v(0) !== 17'd0 || obs_v(0) !== exp_v(0)) begin
      errs++; $display("FAIL idle_ignore: got %h want 0", obs_v(0));
    end
  endtask

  task automatic test_basic_count();
    start[0] = 1'b1; tick();
    vectors++;
    if (run[0] !== 1'b1 || sec[0] !== 7'd0) begin
      errs++; $display("FAIL start_latency: running=%b sec=%0d want 1/0", run[0], sec[0]);
    end
    for (int k = 1; k <= 125; k++) begin
      tick();
      if (k == 9 || k == 10) begin
        vectors++;
        if (sec[0] !== ((k == 10) ? 7'd1 : 7'd0)) begin
          errs++; $display("FAIL first_tick k=%0d: sec=%0d", k, sec[0]);
        end
      end
      vectors++;
      if (obs_v(0) !== exp_v(0)) begin
        errs++; $display("FAIL basic k=%0d: got %h want %h", k, obs_v(0), exp_v(0));
      end
    end
    vectors++;
    if (sec[0] !== 7'd12 || tens[0] !== 4'd1 || ones[0] !== 4'd2) begin
      errs++; $display("FAIL count125: sec=%0d tens=%0d ones=%0d want 12/1/2", sec[0], tens[0], ones[0]);
    end
    stop[0] = 1'b1; tick();
    vectors++;
    if (run[0] !== 1'b0 || sec[0] !== 7'd12) begin
      errs++; $display("FAIL stop_hold: running=%b sec=%0d want 0/12", run[0], sec[0]);
    end
  endtask

  task automatic test_pause_resume();
    start[0] = 1'b1; tick();
    repeat (15) tick();
    vectors++;
    if (sec[0] !== 7'd1) begin
      errs++; $display("FAIL run15: sec=%0d want 1", sec[0]);
    end
    pause[0] = 1'b1; tick();
    repeat (50) tick();
    vectors++;
    if (sec[0] !== 7'd1 || run[0] !== 1'b0) begin
      errs++; $display("FAIL paused: sec=%0d running=%b want 1/0", sec[0], run[0]);
    end
    pause[0] = 1'b1; tick();
    repeat (4) tick();
    vectors++;
    if (sec[0] !== 7'd1 || run[0] !== 1'b1) begin
      errs++; $display("FAIL resume4: sec=%0d running=%b want 1/1", sec[0], run[0]);
    end
    tick();
    vectors++;
    if (sec[0] !== 7'd2 || obs_v(0) !== exp_v(0)) begin
      errs++; $display("FAIL resume5: sec=%0d want 2", sec[0]);
    end
    stop[0] = 1'b1; tick();
  endtask

  task automatic test_limit();
    start[1] = 1'b1; tick();
    repeat (47) tick();
    vectors++;
    if (sec[1] !== 7'd11 || run[1] !== 1'b1 || lim[1] !== 1'b0) begin
      errs++; $display("FAIL pre_limit: sec=%0d running=%b limit=%b want 11/1/0", sec[1], run[1], lim[1]);
    end
    tick();
    vectors++;
    if (obs_v(1) !== {1'b0, 1'b1, 7'd12, 4'd1, 4'd2}) begin
      errs++; $display("FAIL limit: got %h want %h", obs_v(1), {1'b0, 1'b1, 7'd12, 4'd1, 4'd2});
    end
    repeat (20) tick();
    vectors++;
    if (obs_v(1) !== {1'b0, 1'b1, 7'd12, 4'd1, 4'd2} || obs_v(1) !== exp_v(1)) begin
      errs++; $display("FAIL limit_hold: got %h", obs_v(1));
    end
    start[1] = 1'b1; tick();
    vectors++;
    if (lim[1] !== 1'b0 || sec[1] !== 7'd0 || run[1] !== 1'b1) begin
      errs++; $display("FAIL limit_restart: limit=%b sec=%0d running=%b want 0/0/1", lim[1], sec[1], run[1]);
    end
    stop[1] = 1'b1; tick();
  endtask

  task automatic test_priority();
    start[0] = 1'b1; tick();
    repeat (13) tick();
    stop[0] = 1'b1; start[0] = 1'b1; tick();
    vectors++;
    if (run[0] !== 1'b0 || sec[0] !== 7'd1) begin
      errs++; $display("FAIL stop_over_start: running=%b sec=%0d want 0/1", run[0], sec[0]);
    end
    start[0] = 1'b1; tick();
    repeat (9) tick();
    stop[0] = 1'b1; tick();
    vectors++;
    if (run[0] !== 1'b0 || sec[0] !== 7'd0) begin
      errs++; $display("FAIL stop_on_wrap: running=%b sec=%0d want 0/0", run[0], sec[0]);
    end
    start[0] = 1'b1; tick();
    repeat (25) tick();
    rst[0] = 1'b1; start[0] = 1'b1; tick();
    rst[0] = 1'b0;
    vectors++;
    if (obs_v(0) !== 17'd0) begin
      errs++; $display("FAIL rst_over_start: got %h want 0", obs_v(0));
    end
  endtask

  task automatic test_bcd_sweep();
    start[2] = 1'b1; tick();
    for (int k = 0; k < 210; k++) begin
      tick();
      vectors++;
      if (int'(tens[2]) * 10 + int'(ones[2]) != int'(sec[2]) || obs_v(2) !== exp_v(2)) begin
        errs++; $display("FAIL bcd k=%0d: sec=%0d tens=%0d ones=%0d want %h", k, sec[2], tens[2], ones[2], exp_v(2));
      end
    end
    vectors++;
    if (obs_v(2) !== {1'b0, 1'b1, 7'd99, 4'd9, 4'd9}) begin
      errs++; $display("FAIL bcd_limit99: got %h", obs_v(2));
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++) begin
        rst[i]   = ($urandom_range(0, 499) == 0);
        stop[i]  = ($urandom_range(0, 59) == 0);
        pause[i] = ($urandom_range(0, 29) == 0);
        start[i] = (mode[i] != M_RUN) && ($urandom_range(0, 9) == 0);
      end
      tick();
      rst = '0;
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (obs_v(i) !== exp_v(i)) begin
          errs++; $display("FAIL random dut%0d c=%0d: got %h want %h", i, c, obs_v(i), exp_v(i));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_count();
    test_pause_resume();
    test_limit();
    test_priority();
    test_bcd_sweep();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
